// File: rtl/sad_controller.sv
// Sum-of-absolute-differences sequencer: walks N_PIXELS pixel pairs through one
// shared subtractor and accumulates |A-B| into a registered SAD result.
module sad_controller #(
    parameter int DATA_W   = 8,
    parameter int N_PIXELS = 16,
    parameter int ADDR_W   = 4,
    parameter int SAD_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] sub_a,
    output logic [DATA_W-1:0] sub_b,
    input  logic [DATA_W-1:0] sub_diff,
    output logic              busy,
    output logic              done,
    output logic [SAD_W-1:0]  sad,
    output logic              sad_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ACC   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIXELS - 1);
    localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N_PIXELS);

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [SAD_W-1:0]    acc_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_rd_r;
    logic                busy_r;
    logic                done_r;
    logic [SAD_W-1:0]    sad_r;
    logic                sad_valid_r;
    logic                last_s;
    logic [ADDR_W:0]     idx_p2_s;
    logic [SAD_W-1:0]    diff_ext_s;
    logic [SAD_W-1:0]    acc_sum_s;

    assign mem_addr  = mem_addr_r;
    assign mem_rd    = mem_rd_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign sad       = sad_r;
    assign sad_valid = sad_valid_r;

    assign last_s     = (idx_r == LAST_IDX);
    assign idx_p2_s   = {1'b0, idx_r} + (ADDR_W + 1)'(2);
    assign diff_ext_s = {{(SAD_W - DATA_W){1'b0}}, sub_diff};
    assign acc_sum_s  = acc_r + diff_ext_s;

    // Operand steering: the larger pixel is always the minuend.
    always_comb begin
        sub_a = a_data;
        sub_b = b_data;
        if (a_data >= b_data) begin
            sub_a = a_data;
            sub_b = b_data;
        end else begin
            sub_a = b_data;
            sub_b = a_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: state_next_s = ST_ACC;
            ST_ACC: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; outputs are loaded one edge ahead so
    // they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= '0;
            acc_r       <= '0;
            mem_addr_r  <= '0;
            mem_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sad_r       <= '0;
            sad_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        acc_r       <= '0;
                        idx_r       <= '0;
                        sad_valid_r <= 1'b0;
                        mem_rd_r    <= 1'b1;
                        mem_addr_r  <= '0;
                        busy_r      <= 1'b1;
                    end else begin
                        mem_rd_r    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    mem_rd_r   <= 1'b1;
                    mem_addr_r <= ADDR_W'(1);
                end
                ST_ACC: begin
                    acc_r <= acc_sum_s;
                    idx_r <= idx_r + ADDR_W'(1);
                    if (last_s) begin
                        sad_r       <= acc_sum_s;
                        sad_valid_r <= 1'b1;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        mem_rd_r    <= 1'b0;
                    end else if (idx_p2_s < N_EXT) begin
                        mem_rd_r   <= 1'b1;
                        mem_addr_r <= idx_p2_s[ADDR_W-1:0];
                    end else begin
                        mem_rd_r   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    mem_rd_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_controller.sv
// Self-checking bench for sad_controller: pixel memories and subtractor are
// modelled here, expected SAD is summed directly from the pixel arrays.
module tb_sad_controller;

    localparam int DATA_W   = 8;
    localparam int N_PIXELS = 16;
    localparam int ADDR_W   = 4;
    localparam int SAD_W    = 12;

    logic              clk;
    logic              rst_n;
    logic              go;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] sub_a;
    logic [DATA_W-1:0] sub_b;
    logic [DATA_W-1:0] sub_diff;
    logic              busy;
    logic              done;
    logic [SAD_W-1:0]  sad;
    logic              sad_valid;

    int a_mem [N_PIXELS];
    int b_mem [N_PIXELS];

    int n_checks = 0;
    int n_fail   = 0;

    sad_controller #(
        .DATA_W  (DATA_W),
        .N_PIXELS(N_PIXELS),
        .ADDR_W  (ADDR_W),
        .SAD_W   (SAD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .a_data   (a_data),
        .b_data   (b_data),
        .sub_a    (sub_a),
        .sub_b    (sub_b),
        .sub_diff (sub_diff),
        .busy     (busy),
        .done     (done),
        .sad      (sad),
        .sad_valid(sad_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External subtractor.
    assign sub_diff = sub_a - sub_b;

    // Two block memories with one-cycle read latency.
    initial begin
        a_data = '0;
        b_data = '0;
    end
    always @(posedge clk) begin
        if (mem_rd) begin
            a_data <= DATA_W'(a_mem[mem_addr]);
            b_data <= DATA_W'(b_mem[mem_addr]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_sad();
        int s = 0;
        for (int i = 0; i < N_PIXELS; i++) begin
            s += (a_mem[i] > b_mem[i]) ? a_mem[i] - b_mem[i] : b_mem[i] - a_mem[i];
        end
        return s;
    endfunction

    // One block run. Cycle 0 is the IDLE cycle whose go is sampled; outputs
    // are sampled on the falling edge of each cycle. preset: go already high.
    task automatic run_block(input string tag, input bit preset, input int g1, input int g2,
                             input bit chain);
        int exp_sad   = model_sad();
        int done_cnt  = 0;
        int done_cyc  = -1;
        int addr_cnt  = 0;
        int busy_cnt  = 0;
        int svlow_cnt = 0;
        int sad_done  = -1;
        bit addr_ok   = 1'b1;
        if (!preset) begin
            @(negedge clk);
            go = 1'b1;
        end
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge clk);
            go = (cyc == g1) || (cyc == g2) || (chain && cyc == 19);
            if (mem_rd) begin
                if (int'(mem_addr) != addr_cnt) addr_ok = 1'b0;
                addr_cnt++;
            end
            if (busy) busy_cnt++;
            if (!sad_valid && cyc <= 17) svlow_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                sad_done = int'(sad);
                check({tag, " sad_valid@done"}, 32'(sad_valid), 32'd1);
            end
            if (cyc == 19) begin
                check({tag, " idle busy"}, 32'(busy), 32'd0);
                check({tag, " sad hold"}, 32'(sad), 32'(exp_sad));
            end
        end
        check({tag, " done count"}, 32'(done_cnt), 32'd1);
        check({tag, " done cycle"}, 32'(done_cyc), 32'd18);
        check({tag, " sad"}, 32'(sad_done), 32'(exp_sad));
        check({tag, " rd cycles"}, 32'(addr_cnt), 32'd16);
        check({tag, " addr seq"}, 32'(addr_ok), 32'd1);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd17);
        check({tag, " valid low"}, 32'(svlow_cnt), 32'd17);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " sad"}, 32'(sad), 32'd0);
        check({tag, " sad_valid"}, 32'(sad_valid), 32'd0);
    endtask

    initial begin
        bit done_seen;
        rst_n = 1'b0;
        go    = 1'b0;
        for (int i = 0; i < N_PIXELS; i++) begin
            a_mem[i] = 0;
            b_mem[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identical blocks.
        for (int i = 0; i < N_PIXELS; i++) begin a_mem[i] = i; b_mem[i] = i; end
        run_block("equal", 1'b0, -1, -1, 1'b0);

        // Maximum difference, both operand orders.
        for (int i = 0; i < N_PIXELS; i++) begin a_mem[i] = 255; b_mem[i] = 0; end
        run_block("max_ab", 1'b0, -1, -1, 1'b0);
        for (int i = 0; i < N_PIXELS; i++) begin a_mem[i] = 0; b_mem[i] = 255; end
        run_block("max_ba", 1'b0, -1, -1, 1'b0);

        // a=k, b=2k, with go pulses while busy and in DONE.
        for (int i = 0; i < N_PIXELS; i++) begin a_mem[i] = i; b_mem[i] = 2 * i; end
        run_block("mixed", 1'b0, -1, -1, 1'b0);
        run_block("go_ignored", 1'b0, 5, 18, 1'b0);

        // Reset in the middle of a run.
        for (int i = 0; i < N_PIXELS; i++) begin
            a_mem[i] = $urandom_range(255);
            b_mem[i] = $urandom_range(255);
        end
        @(negedge clk);
        go = 1'b1;
        repeat (8) begin
            @(negedge clk);
            go = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        done_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        check("midrst no done", 32'(done_seen), 32'd0);
        run_block("after_rst", 1'b0, -1, -1, 1'b0);

        // Back-to-back runs on different random data.
        run_block("b2b_1", 1'b0, -1, -1, 1'b1);
        for (int i = 0; i < N_PIXELS; i++) begin
            a_mem[i] = $urandom_range(255);
            b_mem[i] = $urandom_range(255);
        end
        run_block("b2b_2", 1'b1, -1, -1, 1'b0);

        // Further random blocks.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_PIXELS; i++) begin
                a_mem[i] = $urandom_range(255);
                b_mem[i] = $urandom_range(255);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            run_block("random", 1'b0, $urandom_range(1, 17), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
